// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared helpers for the pipelined Kogge-Stone adder
package ks_pkg;

  function automatic int ks_levels(input int width);
    int n = 0;
    while ((1 << n) < width) n++;
    return n;
  endfunction

  function automatic int ks_span(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// rtl/ks_prefix_stage.sv - one registered Kogge-Stone prefix level
module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_g,
  input  logic [WIDTH-1:0] prev_p,
  input  logic [WIDTH-1:0] prev_po,
  input  logic             prev_c0,
  output logic             valid,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] po,
  output logic             c0
);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } pg_t;

  pg_t prev_pg;
  pg_t next_pg;
  pg_t pg_q;

  assign prev_pg.g = prev_g;
  assign prev_pg.p = prev_p;

  // Bits below SPAN already hold their final group terms and pass straight through.
  always_comb begin
    next_pg = prev_pg;
    for (int i = SPAN; i < WIDTH; i++) begin
      next_pg.g[i] = prev_pg.g[i] | (prev_pg.p[i] & prev_pg.g[i-SPAN]);
      next_pg.p[i] = prev_pg.p[i] & prev_pg.p[i-SPAN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pg_q  <= '0;
      po    <= '0;
      c0    <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      pg_q  <= next_pg;
      po    <= prev_po;
      c0    <= prev_c0;
    end
  end

  assign g = pg_q.g;
  assign p = pg_q.p;

endmodule

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone add/sub with valid/ready; KS_OVF_EN adds ovf output
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = ks_levels(WIDTH);

  logic advance;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;
  logic [WIDTH-1:0] s0_po;
  logic             s0_c0;

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] p_new;
  logic [WIDTH-1:0] g_new;
  logic             c0_new;

  logic             v_pipe  [0:LEVELS];
  logic [WIDTH-1:0] g_pipe  [0:LEVELS];
  logic [WIDTH-1:0] p_pipe  [0:LEVELS];
  logic [WIDTH-1:0] po_pipe [0:LEVELS];
  logic             c0_pipe [0:LEVELS];
  logic [WIDTH-1:0] p_unused;

  // Global stall: every stage, bubbles included, moves only when the output can drain.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    bb     = sub ? ~b : b;
    c0_new = sub ? 1'b1 : cin;
    p_new  = a ^ bb;
    g_new  = a & bb;
    g_new[0] = g_new[0] | (p_new[0] & c0_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_g     <= '0;
      s0_p     <= '0;
      s0_po    <= '0;
      s0_c0    <= 1'b0;
    end else if (advance) begin
      s0_valid <= in_valid;
      s0_g     <= g_new;
      s0_p     <= p_new;
      s0_po    <= p_new;
      s0_c0    <= c0_new;
    end
  end

  assign v_pipe[0]  = s0_valid;
  assign g_pipe[0]  = s0_g;
  assign p_pipe[0]  = s0_p;
  assign po_pipe[0] = s0_po;
  assign c0_pipe[0] = s0_c0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ks_prefix_stage #(
      .WIDTH (WIDTH),
      .SPAN  (ks_span(k))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance),
      .prev_valid (v_pipe[k-1]),
      .prev_g     (g_pipe[k-1]),
      .prev_p     (p_pipe[k-1]),
      .prev_po    (po_pipe[k-1]),
      .prev_c0    (c0_pipe[k-1]),
      .valid      (v_pipe[k]),
      .g          (g_pipe[k]),
      .p          (p_pipe[k]),
      .po         (po_pipe[k]),
      .c0         (c0_pipe[k])
    );
  end

  // The group propagate of the last level is not needed for the result.
  assign p_unused = p_pipe[LEVELS];

  // G[i] is the carry out of bit i, so the carry into bit i is G[i-1] (c0 for bit 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef KS_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (advance) begin
      out_valid <= v_pipe[LEVELS];
      sum       <= po_pipe[LEVELS] ^ {g_pipe[LEVELS][WIDTH-2:0], c0_pipe[LEVELS]};
      cout      <= g_pipe[LEVELS][WIDTH-1];
`ifdef KS_OVF_EN
      ovf       <= g_pipe[LEVELS][WIDTH-1] ^ g_pipe[LEVELS][WIDTH-2];
`endif
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - self-checking bench for ks_adder_pipe at WIDTH 16 and 4
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        iv16, ir16, ci16, sb16, ov16, or16, co16;
  logic [15:0] a16, b16, s16;
  logic        iv4, ir4, ci4, sb4, ov4, or4, co4;
  logic [3:0]  a4, b4, s4;
  logic        of16_chk, of4_chk;

`ifdef KS_OVF_EN
  logic of16, of4;
  assign of16_chk = of16;
  assign of4_chk  = of4;
`else
  assign of16_chk = 1'b0;
  assign of4_chk  = 1'b0;
`endif

  ks_adder_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef KS_OVF_EN
    , .ovf(of16)
`endif
  );

  ks_adder_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .sub(sb4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
`ifdef KS_OVF_EN
    , .ovf(of4)
`endif
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q [2][$];
  bit          stl [2];
  logic [31:0] hs [2];
  logic        hc [2];
  logic        ho [2];
  bit          lat16 = 1'b0;
  bit          lat4  = 1'b0;

  // Result modelled as plain integer arithmetic: {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
    logic [63:0] mask, yy, t;
    logic [31:0] sm;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    yy   = s ? ((~{32'd0, y}) & mask) : {32'd0, y};
    t    = {32'd0, x} + yy + {63'd0, (s ? 1'b1 : ci)};
    sm   = t[31:0] & mask[31:0];
    co   = t[w];
    ov   = (x[w-1] == yy[w-1]) && (t[w-1] != x[w-1]);
    return {ov, co, sm};
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input int w, input string nm, input logic ov, input logic orr,
                     input logic iv, input logic ir, input logic [31:0] s, input logic c,
                     input logic o, input logic [31:0] av, input logic [31:0] bv,
                     input logic ci, input logic sb, input bit lf);
    exp_t        e;
    logic [33:0] r;
    if (rst) begin
      q[d].delete();
      stl[d] = 1'b0;
      return;
    end
    if (stl[d]) begin
      chk({nm, " stall valid"}, {33'd0, ov}, 34'd1);
      chk({nm, " stall sum"}, {2'b0, s}, {2'b0, hs[d]});
      chk({nm, " stall cout"}, {33'd0, c}, {33'd0, hc[d]});
`ifdef KS_OVF_EN
      chk({nm, " stall ovf"}, {33'd0, o}, {33'd0, ho[d]});
`endif
    end
    if (ov === 1'b1 && orr) begin
      if (q[d].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s spurious result: got sum %0h, want no result", nm, s);
      end else begin
        e = q[d].pop_front();
        chk({nm, " sum"}, {2'b0, s}, {2'b0, e.sum});
        chk({nm, " cout"}, {33'd0, c}, {33'd0, e.cout});
`ifdef KS_OVF_EN
        chk({nm, " ovf"}, {33'd0, o}, {33'd0, e.ovf});
`endif
        if (e.lat) chk({nm, " latency"}, 34'(cyc - e.acc), 34'($clog2(w) + 1));
      end
    end
    stl[d] = (ov === 1'b1) && !orr;
    hs[d]  = s;
    hc[d]  = c;
    ho[d]  = o;
    if (iv && ir) begin
      r      = ref_add(w, av, bv, ci, sb);
      e.sum  = r[31:0];
      e.cout = r[32];
      e.ovf  = r[33];
      e.acc  = cyc + 1;
      e.lat  = lf;
      q[d].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 16, "w16", ov16, or16, iv16, ir16, {16'd0, s16}, co16, of16_chk,
        {16'd0, a16}, {16'd0, b16}, ci16, sb16, lat16);
    mon(1, 4, "w4", ov4, or4, iv4, ir4, {28'd0, s4}, co4, of4_chk,
        {28'd0, a4}, {28'd0, b4}, ci4, sb4, lat4);
  end

  task automatic rnd16();
    a16  = 16'($urandom);
    b16  = 16'($urandom);
    ci16 = 1'($urandom);
    sb16 = 1'($urandom);
  endtask

  task automatic beat16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    a16 = x; b16 = y; ci16 = c; sb16 = s; iv16 = 1'b1; lat16 = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (ir16) break;
      if (n > 50) begin
        chk("w16 accept timeout", {33'd0, ir16}, 34'd1);
        break;
      end
    end
    @(posedge clk); #1;
    iv16 = 1'b0; lat16 = 1'b0;
  endtask

  task automatic beat4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic s);
    a4 = x; b4 = y; ci4 = c; sb4 = s; iv4 = 1'b1; lat4 = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (ir4) break;
      if (n > 50) begin
        chk("w4 accept timeout", {33'd0, ir4}, 34'd1);
        break;
      end
    end
    @(posedge clk); #1;
    iv4 = 1'b0; lat4 = 1'b0;
  endtask

  // stall_at >= n means no stall, and then full throughput is also checked.
  task automatic stream16(input int n, input int stall_at, input int stall_len);
    logic took;
    iv16 = 1'b1;
    rnd16();
    for (int c = 0; c < n; c++) begin
      or16 = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      took = ir16;
      if (or16) chk("w16 in_ready running", {33'd0, ir16}, 34'd1);
      else      chk("w16 in_ready stalled", {33'd0, ir16}, 34'd0);
      if (stall_at >= n && c >= 6) chk("w16 throughput", {33'd0, ov16}, 34'd1);
      @(posedge clk); #1;
      if (took) rnd16();
    end
    iv16 = 1'b0;
    or16 = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 80 && (q[0].size() != 0 || q[1].size() != 0); n++) @(negedge clk);
    chk("w16 drained", 34'(q[0].size()), 34'd0);
    chk("w4 drained", 34'(q[1].size()), 34'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0; or16 = 1;
    iv4  = 0; a4  = 0; b4  = 0; ci4  = 0; sb4  = 0; or4  = 1;

    chk("model 7+9 w4", ref_add(4, 32'h7, 32'h9, 1'b0, 1'b0), 34'h1_0000_0000);
    chk("model ffff+0+1", ref_add(16, 32'hFFFF, 32'h0, 1'b1, 1'b0), 34'h1_0000_0000);
    chk("model 5-7", ref_add(16, 32'h5, 32'h7, 1'b0, 1'b1), 34'h0_0000_FFFE);
    chk("model 8000-1", ref_add(16, 32'h8000, 32'h1, 1'b0, 1'b1), 34'h3_0000_7FFF);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {33'd0, ov16}, 34'd0);
    chk("reset sum", {18'd0, s16}, 34'd0);
    chk("reset cout", {33'd0, co16}, 34'd0);
    chk("reset in_ready", {33'd0, ir16}, 34'd1);
    chk("reset w4 out_valid", {33'd0, ov4}, 34'd0);
    chk("reset w4 in_ready", {33'd0, ir4}, 34'd1);
`ifdef KS_OVF_EN
    chk("reset ovf", {33'd0, of16}, 34'd0);
`endif
    @(posedge clk); #1;

    beat4(4'h7, 4'h9, 1'b0, 1'b0);
    beat16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    beat16(16'h0005, 16'h0007, 1'b0, 1'b1);
    beat16(16'h8000, 16'h0001, 1'b0, 1'b1);
    beat16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();

    stream16(20, 20, 0);
    drain();

    stream16(24, 10, 4);
    drain();

    // Random valid and random backpressure on the narrow instance.
    for (int c = 0; c < 60; c++) begin
      or4 = ($urandom_range(0, 2) != 0);
      if (!iv4) begin
        iv4 = ($urandom_range(0, 3) != 0);
        a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); sb4 = 1'($urandom);
      end
      @(negedge clk);
      if (ir4) begin
        @(posedge clk); #1;
        iv4 = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    drain();

    iv16 = 1'b1;
    rnd16();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
      rnd16();
    end
    iv16 = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush out_valid", {33'd0, ov16}, 34'd0);
    chk("flush sum", {18'd0, s16}, 34'd0);
    chk("flush cout", {33'd0, co16}, 34'd0);
    chk("flush in_ready", {33'd0, ir16}, 34'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    beat16(16'h1234, 16'h4321, 1'b1, 1'b0);
    beat4(4'h3, 4'h5, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
